// File: rtl/pe_tile_sequencer.sv
// pe_tile_sequencer: control sequencer that runs one tile through the systolic array.
// A tile goes through four phases: weight load, settle, activation streaming, then pipeline drain.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, tile_len     : tile start pulse and activation beat count (sampled in IDLE)
//   cfg_we/sel/addr     : outlier mux configuration write (IDLE only)
//   wt_valid_*/wt_data_*: per-lane candidate weight banks, index 0 has highest priority
//   act_valid/act_ready : activation handshake (ready only in COMPUTE)
//   wt_out_*, wt_out_valid, load_weight_en : registered weight path to the array
//   outlier_sel/addr    : outlier mux configuration registers
//   out_valid, out_cnt  : aligned post-process valid and its per-tile beat count
//   pingpang, busy, tile_done : write-back bank select, activity flag, completion pulse
module pe_tile_sequencer #(
    parameter int unsigned ROWS     = 32,
    parameter int unsigned POST_LAT = 3,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned BANK_W   = 64,
    parameter int unsigned NUM_MUX  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [15:0]             tile_len,
    input  logic                    cfg_we,
    input  logic [NUM_MUX-1:0]      cfg_sel,
    input  logic [6*NUM_MUX-1:0]    cfg_addr,
    input  logic [NUM_SRC-1:0]      wt_valid_a,
    input  logic [NUM_SRC*BANK_W-1:0] wt_data_a,
    input  logic [NUM_SRC-1:0]      wt_valid_b,
    input  logic [NUM_SRC*BANK_W-1:0] wt_data_b,
    input  logic                    act_valid,
    output logic                    act_ready,
    output logic [BANK_W-1:0]       wt_out_a,
    output logic [BANK_W-1:0]       wt_out_b,
    output logic                    wt_out_valid,
    output logic                    load_weight_en,
    output logic [NUM_MUX-1:0]      outlier_sel,
    output logic [6*NUM_MUX-1:0]    outlier_addr,
    output logic                    out_valid,
    output logic [15:0]             out_cnt,
    output logic                    pingpang,
    output logic                    busy,
    output logic                    tile_done
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DL_W  = ROWS + POST_LAT;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_COMPUTE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   tile_len_q;
    logic               settle_cnt;
    logic [DL_W-1:0]    dl_q;
    logic [BANK_W-1:0]  sel_a_c;
    logic [BANK_W-1:0]  sel_b_c;
    logic               start_c;
    logic               cfg_wr_c;
    logic               wt_accept_c;
    logic               act_accept_c;
    logic               drain_done_c;

    // Priority select: scanning from the top down lets the lowest set index win.
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (wt_valid_a[i]) sel_a_c = wt_data_a[i*BANK_W +: BANK_W];
            if (wt_valid_b[i]) sel_b_c = wt_data_b[i*BANK_W +: BANK_W];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        next_state   = state;
        start_c      = 1'b0;
        cfg_wr_c     = 1'b0;
        wt_accept_c  = 1'b0;
        act_accept_c = 1'b0;
        drain_done_c = 1'b0;
        case (state)
            S_IDLE: begin
                cfg_wr_c = cfg_we;
                if (start) begin
                    start_c    = 1'b1;
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                // Leave once the counter holds ROWS; no further beats are taken then.
                if (beat_cnt == CNT_W'(ROWS)) next_state = S_SETTLE;
                else                          wt_accept_c = |wt_valid_a;
            end
            S_SETTLE: begin
                if (settle_cnt) next_state = (tile_len_q == '0) ? S_DRAIN : S_COMPUTE;
            end
            S_COMPUTE: begin
                act_accept_c = act_valid & act_ready;
                if (act_accept_c && (beat_cnt + CNT_W'(1)) == tile_len_q) next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (dl_q == '0) begin
                    drain_done_c = 1'b1;
                    next_state   = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt       <= '0;
            tile_len_q     <= '0;
            settle_cnt     <= 1'b0;
            dl_q           <= '0;
            act_ready      <= 1'b0;
            wt_out_a       <= '0;
            wt_out_b       <= '0;
            wt_out_valid   <= 1'b0;
            load_weight_en <= 1'b0;
            outlier_sel    <= '0;
            outlier_addr   <= '0;
            out_cnt        <= '0;
            pingpang       <= 1'b0;
            busy           <= 1'b0;
            tile_done      <= 1'b0;
        end else begin
            if (start_c) tile_len_q <= tile_len;

            if (start_c || (state == S_LOAD && next_state == S_SETTLE)) beat_cnt <= '0;
            else if (wt_accept_c || act_accept_c)                       beat_cnt <= beat_cnt + CNT_W'(1);

            settle_cnt <= (state == S_SETTLE) ? ~settle_cnt : 1'b0;

            if (cfg_wr_c) begin
                outlier_sel  <= cfg_sel;
                outlier_addr <= cfg_addr;
            end

            if (wt_accept_c) begin
                wt_out_a <= sel_a_c;
                wt_out_b <= sel_b_c;
            end
            wt_out_valid   <= wt_accept_c;
            load_weight_en <= wt_out_valid;

            // Shifting weights invalidates anything in flight through the array.
            if (load_weight_en) dl_q <= '0;
            else                dl_q <= {dl_q[DL_W-2:0], act_accept_c};

            if (start_c)                           out_cnt <= '0;
            else if (out_valid && out_cnt != '1)   out_cnt <= out_cnt + CNT_W'(1);

            act_ready <= (next_state == S_COMPUTE);
            busy      <= (next_state != S_IDLE);
            tile_done <= drain_done_c;
            if (drain_done_c) pingpang <= ~pingpang;
        end
    end

    assign out_valid = dl_q[DL_W-1];

endmodule
